// File: rtl/enc_pkg.sv
// Shared types and constants for the encryption sequencer: FSM states,
// the LFSR tap table and the padding/seed constants.
package enc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG0,
    S_CFG1,
    S_CFG2,
    S_CFG3,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int         NUM_PTRN     = 9;
  localparam logic [3:0] PTRN_LAST    = 4'(NUM_PTRN - 1);
  localparam logic [7:0] SPACE        = 8'h20;
  localparam logic [6:0] DEFAULT_SEED = 7'h01;

  // Feedback masks for the 7-bit maximal-length LFSR, one per pattern index.
  localparam logic [6:0] TAP_TABLE [NUM_PTRN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Out-of-range pattern indices fall back to pattern 0.
  function automatic logic [6:0] tap_lookup(input logic [3:0] idx);
    logic [6:0] t;
    t = TAP_TABLE[0];
    for (int k = 0; k < NUM_PTRN; k++) begin
      if (idx == 4'(k)) t = TAP_TABLE[k];
    end
    return t;
  endfunction

  function automatic logic [7:0] add_parity(input logic [7:0] c);
    return {^c[6:0], c[6:0]};
  endfunction

endpackage

// File: rtl/encrypt_sequencer_lfsr7.sv
// 7-bit Fibonacci-style LFSR: parallel load of a seed, single-step shift
// with the feedback bit formed as the parity of the tapped state bits.
module lfsr7
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [6:0] i_seed,
  input  logic [6:0] i_taps,
  output logic [6:0] o_q
);

  logic [6:0] r_q;
  logic [6:0] w_next;

  assign w_next = {r_q[5:0], ^(r_q & i_taps)};
  assign o_q    = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= DEFAULT_SEED;
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_step) begin
      r_q <= w_next;
    end
  end

endmodule

// File: rtl/encrypt_sequencer.sv
// Memory-driven encryption job: reads config, builds the space-padded message
// on the fly, XORs with the LFSR, adds even parity and writes the output block.
module encrypt_sequencer
  import enc_pkg::*;
#(
  parameter int AW       = 8,
  parameter int MSG_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int OUT_BASE = 64,
  parameter int NUM_OUT  = 64,
  parameter int MSG_MAX  = 61
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          req,
  output logic          ack,
  output logic          busy,
  output logic          err_ptn,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wr_en,
  output logic [7:0]    dm_wr_data,
  input  logic [7:0]    dm_rd_data
);

  state_t        r_state, w_state_nxt;
  logic          r_armed, r_ack, r_busy, r_err;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_pre;
  logic [3:0]    r_pt;
  logic [6:0]    r_taps;

  logic [AW:0]   w_diff;
  logic          w_in_msg, w_last;
  logic [7:0]    w_padded;
  logic [6:0]    w_seed, w_lfsr;
  logic          w_load, w_step;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [7:0]    w_wdata;

  // The extra top bit flags i < pre, so a large pre never wraps into the message.
  assign w_diff   = {1'b0, r_idx} - (AW+1)'(r_pre);
  assign w_in_msg = !w_diff[AW] && (w_diff < (AW+1)'(MSG_MAX));
  assign w_last   = (r_idx == AW'(NUM_OUT - 1));
  assign w_padded = w_in_msg ? dm_rd_data : SPACE;
  assign w_seed   = (dm_rd_data[6:0] == 7'd0) ? DEFAULT_SEED : dm_rd_data[6:0];

  lfsr7 u_lfsr (
    .clk    (clk),
    .rst_n  (init_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_seed (w_seed),
    .i_taps (r_taps),
    .o_q    (w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr      = '0;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE:  if (r_armed && !req) w_state_nxt = S_CFG0;
      S_CFG0: begin
        w_addr      = AW'(CFG_BASE);
        w_state_nxt = S_CFG1;
      end
      S_CFG1: begin
        w_addr      = AW'(CFG_BASE + 1);
        w_state_nxt = S_CFG2;
      end
      S_CFG2: begin
        w_addr      = AW'(CFG_BASE + 2);
        w_state_nxt = S_CFG3;
      end
      S_CFG3: begin
        w_load      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_in_msg) w_addr = AW'(MSG_BASE) + w_diff[AW-1:0];
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_addr      = AW'(OUT_BASE) + r_idx;
        w_we        = 1'b1;
        w_wdata     = add_parity(w_padded ^ {1'b0, w_lfsr});
        w_step      = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_DONE:  if (req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_busy  <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
          end
        end
        S_CFG3:  r_err <= (r_pt > PTRN_LAST);
        S_WRITE: begin
          r_idx <= r_idx + AW'(1);
          if (w_last) begin
            r_busy <= 1'b0;
            r_ack  <= 1'b1;
          end
        end
        S_DONE: begin
          if (req) begin
            r_ack   <= 1'b0;
            r_armed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Config data registers: captured one cycle after their address was issued.
  always_ff @(posedge clk) begin
    if (r_state == S_CFG1) r_pre  <= dm_rd_data;
    if (r_state == S_CFG2) r_pt   <= dm_rd_data[3:0];
    if (r_state == S_CFG3) r_taps <= tap_lookup(r_pt);
  end

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign err_ptn    = r_err;
  assign dm_addr    = w_addr;
  assign dm_wr_en   = w_we;
  assign dm_wr_data = w_wdata;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Directed and randomized jobs for encrypt_sequencer against a behavioural
// model of the padded-message / LFSR / parity encryption.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_cmp++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
    end \
  end

module tb_encrypt_sequencer;

  logic       clk = 1'b0;
  logic       init_n;
  logic       req;
  logic       ack, busy, err_ptn;
  logic [7:0] dm_addr;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;
  logic [7:0] dm_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] img  [64];
  logic [7:0] outm [64];
  int         wr_total = 0;
  int         bad_wr   = 0;

  logic [7:0] exp_out [64];
  logic       exp_err;
  logic [7:0] snap_a  [64];

  int unsigned TAPS [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

  encrypt_sequencer dut (
    .clk        (clk),
    .init_n     (init_n),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .err_ptn    (err_ptn),
    .dm_addr    (dm_addr),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data),
    .dm_rd_data (dm_rd_data)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous read, input image below 64, output block above.
  always @(posedge clk) begin
    if (dm_wr_en) begin
      wr_total <= wr_total + 1;
      if (dm_addr >= 8'd64) outm[dm_addr - 8'd64] <= dm_wr_data;
      else bad_wr <= bad_wr + 1;
    end
    dm_rd_data <= (dm_addr < 8'd64) ? img[dm_addr[5:0]] : outm[dm_addr - 8'd64];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg_watson;
    string s;
    s = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 61; k++) img[k] = (k < s.len()) ? s[k] : 8'h20;
  endtask

  task automatic set_msg_random;
    for (int k = 0; k < 61; k++) img[k] = 8'($urandom_range(32, 126));
  endtask

  task automatic set_cfg(input logic [7:0] pre, input logic [7:0] pt, input logic [7:0] seed);
    img[61] = pre;
    img[62] = pt;
    img[63] = seed;
  endtask

  // Reference: pad message with spaces at offset pre, encrypt with the LFSR stream.
  task automatic compute_model;
    int pre, idx, pos;
    int unsigned lfsr, taps, c, fb;
    logic [7:0] p;
    pre  = int'(img[61]);
    idx  = int'(img[62]) % 16;
    lfsr = int'(img[63]) % 128;
    if (lfsr == 0) lfsr = 1;
    exp_err = (idx > 8);
    taps = TAPS[(idx > 8) ? 0 : idx];
    for (int i = 0; i < 64; i++) begin
      pos = i - pre;
      p = (pos >= 0 && pos < 61) ? img[pos] : 8'h20;
      c = (int'(p) ^ lfsr) % 128;
      if ($countones(c) % 2 == 1) c = c + 128;
      exp_out[i] = 8'(c);
      fb   = $countones(lfsr & taps) % 2;
      lfsr = ((lfsr * 2) + fb) % 128;
    end
  endtask

  task automatic check_output(input string tag);
    compute_model();
    for (int i = 0; i < 64; i++)
      `CHK($sformatf("%s byte %0d", tag, i), outm[i], exp_out[i])
    `CHK({tag, " err_ptn"}, err_ptn, exp_err)
  endtask

  task automatic launch(input string tag);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    `CHK({tag, " busy at launch"}, busy, 1'b1)
    `CHK({tag, " err cleared at launch"}, err_ptn, 1'b0)
  endtask

  task automatic wait_done(input string tag, input int start_edge);
    int edge_n;
    edge_n = start_edge;
    while (ack !== 1'b1 && edge_n < 400) begin
      tick();
      edge_n++;
    end
    `CHK({tag, " ack edge"}, edge_n, 133)
    `CHK({tag, " busy after ack"}, busy, 1'b0)
  endtask

  task automatic run_job(input string tag);
    int wr0;
    wr0 = wr_total;
    launch(tag);
    wait_done(tag, 1);
    `CHK({tag, " write count"}, wr_total - wr0, 64)
    check_output(tag);
  endtask

  initial begin
    int wr0, same;
    init_n = 1'b0;
    req    = 1'b0;
    for (int k = 0; k < 64; k++) begin
      img[k]  = 8'h00;
      outm[k] = 8'h00;
    end
    tick();
    tick();
    `CHK("reset outputs", {ack, busy, err_ptn, dm_wr_en, dm_addr, dm_wr_data}, 20'h0)
    init_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    `CHK("req low never launches busy", busy, 1'b0)
    `CHK("req low never launches writes", wr_total, 0)

    set_msg_watson();
    set_cfg(8'd10, 8'd0, 8'h01);
    run_job("job A");
    `CHK("job A out0", outm[0], 8'h21)
    `CHK("job A out1", outm[1], 8'h22)
    for (int k = 0; k < 64; k++) snap_a[k] = outm[k];

    set_cfg(8'd15, 8'd1, 8'h7F);
    run_job("job B");
    `CHK("job B out0", outm[0], 8'h5F)

    set_cfg(8'd10, 8'd0, 8'h00);
    run_job("job C seed0");
    same = 0;
    for (int k = 0; k < 64; k++) if (outm[k] === snap_a[k]) same++;
    `CHK("seed0 equals seed1 run", same, 64)

    set_cfg(8'd10, 8'd9, 8'h01);
    run_job("job D pt9");
    `CHK("pt9 err_ptn", err_ptn, 1'b1)
    same = 0;
    for (int k = 0; k < 64; k++) if (outm[k] === snap_a[k]) same++;
    `CHK("pt9 equals pt0 run", same, 64)

    set_cfg(8'd10, 8'd2, 8'h01);
    run_job("job E pt2");

    set_cfg(8'd3, 8'd5, 8'h35);
    wr0 = wr_total;
    launch("job R");
    for (int k = 0; k < 44; k++) tick();
    #2 init_n = 1'b0;
    #1;
    `CHK("mid-job reset outputs", {ack, busy, err_ptn, dm_wr_en, dm_addr, dm_wr_data}, 20'h0)
    `CHK("writes before reset", wr_total - wr0, 20)
    #2 init_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    `CHK("no writes after reset", wr_total - wr0, 20)
    `CHK("idle after reset", busy, 1'b0)
    run_job("job R relaunch");

    for (int k = 0; k < 20; k++) tick();
    `CHK("no relaunch ack held", ack, 1'b1)
    `CHK("no relaunch busy", busy, 1'b0)
    req = 1'b1;
    tick();
    `CHK("req high drops ack", ack, 1'b0)
    `CHK("req high no job", busy, 1'b0)
    set_msg_random();
    set_cfg(8'd0, 8'd7, 8'h5A);
    req = 1'b0;
    tick();
    `CHK("second job busy", busy, 1'b1)
    wait_done("second job", 1);
    check_output("second job");

    for (int j = 0; j < 4; j++) begin
      set_msg_random();
      set_cfg((j == 3) ? 8'd255 : 8'($urandom_range(0, 70)), 8'($urandom), 8'($urandom));
      run_job($sformatf("random job %0d", j));
    end

    `CHK("no writes below output block", bad_wr, 0)
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`undef CHK

// File: doc/encrypt_sequencer.md
Name: encrypt_sequencer

Overview:
- Hardware controller that runs the Program 1 encryption job directly against data memory, with no instruction ROM.
- Reads config (pre_length, tap-pattern index, LFSR seed) from DM[61..63].
- Builds the space-padded message on the fly, XORs each byte with a 7-bit maximal-length LFSR, inserts the even-parity MSB, and writes 64 bytes to DM[64..127].
- Sits beside data memory in top_level and uses the same req/ack launch handshake as the program-driven design.

Parameters:
- AW, 8, data-memory address width
- MSG_BASE, 0, address of first message character
- CFG_BASE, 61, address of pre_length; pt_no is at CFG_BASE+1, seed at CFG_BASE+2
- OUT_BASE, 64, address of first encrypted output byte
- NUM_OUT, 64, number of output bytes
- MSG_MAX, 61, message bytes available starting at MSG_BASE

Ports:
- clk  in  1  system clock, rising edge
- init_n  in  1  reset, asynchronous assert, active-low
- req  in  1  launch request: held 1 = hold, falling to 0 = launch
- ack  out  1  job complete
- busy  out  1  job in progress
- err_ptn  out  1  pt_no[3:0] > 8 seen in the current job
- dm_addr  out  AW  memory address
- dm_wr_en  out  1  write strobe
- dm_wr_data  out  8  write data
- dm_rd_data  in  8  read data, valid the cycle after dm_addr is presented

Behaviour:
- Reset (init_n=0, async): state=IDLE, armed=0; ack, busy, err_ptn, dm_wr_en, dm_addr, dm_wr_data all 0.
- Arming:
  - In IDLE, sampling req=1 sets armed=1.
  - Sampling req=0 while armed=1 launches the job: busy=1, ack=0, err_ptn=0, armed=0.
  - A req that stays low after reset never launches.
- States: IDLE -> CFG0 -> CFG1 -> CFG2 -> CFG3 -> FETCH <-> WRITE -> DONE.
- Config phase, one cycle each:
  - CFG0 issues addr CFG_BASE.
  - CFG1 issues CFG_BASE+1 and captures pre.
  - CFG2 issues CFG_BASE+2 and captures pt.
  - CFG3 captures seed.
  - Also in CFG3: seed[6:0]==0 is replaced by 7'h01. pt[3:0] in 9..15 selects pattern 0 and sets err_ptn (sticky until next launch).
- Tap table indexed 0..8: 60, 48, 78, 72, 6A, 69, 5C, 7E, 7B (hex).
- Byte loop, index i = 0..NUM_OUT-1, 2 cycles per byte:
  - FETCH: if pre <= i < pre+MSG_MAX, drive dm_addr = MSG_BASE+(i-pre). Otherwise the padded byte is 8'h20 and the read data is ignored.
  - WRITE:
    - c = padded ^ {1'b0, lfsr}
    - c[7] = ^c[6:0]
    - drive dm_addr = OUT_BASE+i, dm_wr_data = c, dm_wr_en = 1 for exactly this cycle
    - step lfsr_next = {lfsr[5:0], ^(lfsr & taps)}
  - lfsr for i=0 is the seed.
  - The i-pre subtraction is done at AW+1 bits, so there is no wrap; pre up to 255 is legal (all-space output when pre >= 64).
- Latency: the launch edge is edge 1. CFG takes 4 edges and bytes take 128, so ack and busy=0 are registered on edge 133.
- dm_wr_en is 0 outside WRITE.
- DONE: ack=1 held until req is sampled 1, then go to IDLE with armed=1 and ack=0. No auto-relaunch.
- req changes while busy are ignored.
- init_n asserted mid-job: immediate return to IDLE. Bytes already written stay in memory; no write is in flight after reset.

Decomposition:
- Package enc_pkg holds:
  - state enum
  - the 9-entry tap table, as a 7-bit localparam array
  - constants SPACE=8'h20, NUM_PTRN=9, DEFAULT_SEED=7'h01
- Sub-module lfsr7: 7-bit register with load/step/taps ports and a comb next-state. It is instanced once.
- All other logic (FSM, byte counter, address mux, parity) stays in encrypt_sequencer.

Test Plan:
- pre=10, pt=0 (taps 60), seed=01, msg "Mr. Watson, come here. I want to see you." -> out[0]=0x21, out[1]=0x22; all 64 bytes match the bench model; ack registered on edge 133 after launch.
- pt=1 (taps 48), seed=7F -> out[0]=0x5F; pre=15, so bytes 0..14 encrypt 0x20.
- seed=00 -> output identical to the seed=01 run, err_ptn=0.
- pt=9 -> err_ptn=1 and output identical to the pt=0 run; next launch with pt=2 -> err_ptn cleared to 0.
- init_n pulsed low at byte 20 -> outputs immediately 0; relaunch (req 1 then 0) -> full correct 64-byte result.
- req held 0 after ack -> no second job; req 1 -> ack=0; req 0 -> second job runs.
